pin_pattern_gen: RTL

Board bring-up pattern sequencer that drives the FPGA's user I/O bank through a repeating all-on / walking-one / all-off cycle, one step per prescaled tick. It sits directly upstream of the I/O pin bank and replaces the static all-ones pin-check assignment. A tester can then confirm that every pin toggles, is individually addressable, and is not shorted to a neighbour. Loop completion is reported on `done` and `loop_cnt` for on-board status or a logic analyser.

---
 rtl/pin_pattern_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pin_pattern_gen.sv
// Board bring-up pattern sequencer: cycles the user I/O bank through
// all-on, walking-one and all-off phases, advancing one step per prescaled tick.
module pin_pattern_gen #(
  parameter int WIDTH = 40,
  parameter int DIV   = 12000000,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] pins,
  output logic [1:0]       mode,
  output logic             tick,
  output logic             done,
  output logic [7:0]       loop_cnt
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int STEP_N = (WIDTH > HOLD) ? WIDTH : HOLD;
  localparam int STEP_W = (STEP_N > 1) ? $clog2(STEP_N) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [STEP_W-1:0] HOLD_LAST  = STEP_W'(HOLD - 1);
  localparam logic [STEP_W-1:0] WIDTH_LAST = STEP_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_ALL_ON  = 2'd0,
    ST_WALK    = 2'd1,
    ST_ALL_OFF = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  pins_q, pins_d;
  logic              done_q, done_d;
  logic [7:0]        loop_q, loop_d;

  assign tick     = en && (div_cnt == DIV_LAST);
  assign pins     = pins_q;
  assign mode     = state_q;
  assign done     = done_q;
  assign loop_cnt = loop_q;

  // Prescaler: free-running while enabled, frozen (not cleared) while disabled.
  // NOTE: every register here is written with <= so all flops sample the same
  // pre-edge values; blocking assignments in a clocked block create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Next-state logic. Everything holds unless a tick fires; done is the
  // exception and self-clears on any edge where it is not being set.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pins_d  = pins_q;
    loop_d  = loop_q;
    done_d  = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_ALL_ON: begin
          if (step_q == HOLD_LAST) begin
            state_d = ST_WALK;
            step_d  = '0;
            pins_d  = WIDTH'(1);
          end else begin
            step_d  = step_q + STEP_W'(1);
          end
        end
        ST_WALK: begin
          if (step_q == WIDTH_LAST) begin
            state_d = ST_ALL_OFF;
            step_d  = '0;
            pins_d  = '0;
          end else begin
            step_d  = step_q + STEP_W'(1);
            pins_d  = {pins_q[WIDTH-2:0], 1'b0};
          end
        end
        ST_ALL_OFF: begin
          if (step_q == HOLD_LAST) begin
            state_d = ST_ALL_ON;
            step_d  = '0;
            pins_d  = '1;
            done_d  = 1'b1;
            loop_d  = loop_q + 8'd1;
          end else begin
            step_d  = step_q + STEP_W'(1);
          end
        end
        default: begin
          state_d = ST_ALL_ON;
          step_d  = '0;
          pins_d  = '1;
        end
      endcase
    end
  end

  // Pattern registers: pins leave the block straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ALL_ON;
      step_q  <= '0;
      pins_q  <= '1;
      done_q  <= 1'b0;
      loop_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pins_q  <= pins_d;
      done_q  <= done_d;
      loop_q  <= loop_d;
    end
  end

endmodule
